// File: rtl/nonce_sweeper.sv
// Nonce sweeper: launches {prefix, nonce} messages into the miner core one at a time,
// waits out the core's fixed hash latency and keeps the first nonce whose hash is valid.
module nonce_sweeper #(
    parameter int HASH_LATENCY = 230,
    parameter int PREFIX_W     = 376
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PREFIX_W-1:0]    header_prefix,
    input  logic [408-PREFIX_W-1:0] nonce_start,
    input  logic [408-PREFIX_W-1:0] nonce_end,
    input  logic                   validBTC,
    input  logic [255:0]           SHAoutput,
    output logic                   newMsg,
    output logic [407:0]           inputMsg,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [408-PREFIX_W-1:0] found_nonce,
    output logic [255:0]           found_hash,
    output logic [31:0]            hash_count
);

    localparam int NONCE_W = 408 - PREFIX_W;
    localparam int CNT_W   = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(HASH_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [PREFIX_W-1:0]  r_prefix;
    logic [NONCE_W-1:0]   r_nonce;
    logic [NONCE_W-1:0]   r_end;
    logic [CNT_W-1:0]     r_waitCnt;
    logic                 r_found;
    logic                 r_exhausted;
    logic [NONCE_W-1:0]   r_foundNonce;
    logic [255:0]         r_foundHash;
    logic [31:0]          r_hashCount;

    logic                 w_accept;
    logic                 w_waitDone;
    logic                 w_lastNonce;

    assign w_accept    = start && !abort;
    assign w_waitDone  = (r_waitCnt == LAST_WAIT);
    assign w_lastNonce = (r_nonce == r_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort wins over everything once a sweep is running, including the CHECK outcome.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_nextState = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    w_nextState = S_IDLE;
                end else if (w_waitDone) begin
                    w_nextState = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || validBTC || w_lastNonce) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_nextState = S_LAUNCH;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_comb begin
        newMsg = (r_state == S_LAUNCH) && !abort;
        busy   = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prefix     <= '0;
            r_nonce      <= '0;
            r_end        <= '0;
            r_waitCnt    <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_foundNonce <= '0;
            r_foundHash  <= '0;
            r_hashCount  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_prefix     <= header_prefix;
                        r_nonce      <= nonce_start;
                        r_end        <= nonce_end;
                        r_found      <= 1'b0;
                        r_exhausted  <= 1'b0;
                        r_foundNonce <= '0;
                        r_foundHash  <= '0;
                        r_hashCount  <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_waitCnt <= '0;
                end
                S_WAIT: begin
                    r_waitCnt <= r_waitCnt + CNT_W'(1);
                end
                S_CHECK: begin
                    // An aborted CHECK leaves count, nonce and result flags untouched.
                    if (!abort) begin
                        if (r_hashCount != '1) begin
                            r_hashCount <= r_hashCount + 32'd1;
                        end
                        if (validBTC) begin
                            r_found      <= 1'b1;
                            r_foundNonce <= r_nonce;
                            r_foundHash  <= SHAoutput;
                        end else if (w_lastNonce) begin
                            r_exhausted <= 1'b1;
                        end else begin
                            r_nonce <= r_nonce + NONCE_W'(1);
                        end
                    end
                end
                default: begin
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

    assign inputMsg    = {r_prefix, r_nonce};
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign found_nonce = r_foundNonce;
    assign found_hash  = r_foundHash;
    assign hash_count  = r_hashCount;

endmodule
